// File: rtl/tpx3_out_stage_if.sv
// Bus bundle for tpx3_out_stage: upstream FWFT pop side, downstream FIFO side,
// heartbeat configuration and status counters.
interface tpx3_out_stage_if #(
  parameter int HB_PERIOD_WIDTH = 24
);
  logic                       IN_EMPTY;
  logic [31:0]                IN_DATA;
  logic                       IN_READ;
  logic                       OUT_READ;
  logic                       OUT_EMPTY;
  logic [31:0]                OUT_DATA;
  logic                       HB_EN;
  logic [HB_PERIOD_WIDTH-1:0] HB_PERIOD;
  logic [31:0]                WORD_CNT;
  logic [27:0]                HB_CNT;
  logic                       FULL;

  modport master (
    output IN_EMPTY, IN_DATA, OUT_READ, HB_EN, HB_PERIOD,
    input  IN_READ, OUT_EMPTY, OUT_DATA, WORD_CNT, HB_CNT, FULL
  );

  modport slave (
    input  IN_EMPTY, IN_DATA, OUT_READ, HB_EN, HB_PERIOD,
    output IN_READ, OUT_EMPTY, OUT_DATA, WORD_CNT, HB_CNT, FULL
  );
endinterface

// File: rtl/tpx3_out_stage.sv
// Elastic register FIFO between readout arbiter and BRAM output FIFO, with
// word counting and idle-time heartbeat insertion.
module tpx3_out_stage #(
  parameter int         DEPTH           = 4,
  parameter logic [3:0] HB_IDENTIFIER   = 4'b1010,
  parameter int         HB_PERIOD_WIDTH = 24
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  tpx3_out_stage_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]                mem_q [DEPTH];
  logic [31:0]                mem_d [DEPTH];
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [31:0]                word_cnt_q, word_cnt_d;
  logic [27:0]                hb_cnt_q, hb_cnt_d;
  logic [HB_PERIOD_WIDTH-1:0] idle_q, idle_d;
  logic                       hb_pending_q, hb_pending_d;

  logic        full, empty, data_push, hb_push, push, pop;
  logic        hb_active, hb_expire;
  logic [31:0] push_word;

  // FULL is taken from the registered count only, so a pop never opens IN_READ
  // in the same cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign data_push = !bus.IN_EMPTY && !full;
  assign hb_push   = hb_pending_q && !full && !data_push;
  assign push      = data_push || hb_push;
  assign pop       = bus.OUT_READ && !empty;
  assign hb_active = bus.HB_EN && (bus.HB_PERIOD != '0);
  assign hb_expire = hb_active && !data_push &&
                     (idle_q == (bus.HB_PERIOD - HB_PERIOD_WIDTH'(1)));
  assign push_word = data_push ? bus.IN_DATA : {HB_IDENTIFIER, hb_cnt_q};

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    word_cnt_d   = word_cnt_q;
    hb_cnt_d     = hb_cnt_q;
    idle_d       = idle_q;
    hb_pending_d = hb_pending_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (data_push) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
    if (hb_push) begin
      hb_cnt_d = hb_cnt_q + 28'd1;
    end

    if (!hb_active || data_push || hb_expire) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + HB_PERIOD_WIDTH'(1);
    end

    // Only one heartbeat can be outstanding; data makes a pending one redundant.
    if (hb_expire) begin
      hb_pending_d = 1'b1;
    end else if (push) begin
      hb_pending_d = 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      word_cnt_q   <= '0;
      hb_cnt_q     <= '0;
      idle_q       <= '0;
      hb_pending_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      word_cnt_q   <= word_cnt_d;
      hb_cnt_q     <= hb_cnt_d;
      idle_q       <= idle_d;
      hb_pending_q <= hb_pending_d;
    end
  end

  assign bus.IN_READ   = data_push;
  assign bus.OUT_EMPTY = empty;
  assign bus.OUT_DATA  = mem_q[rd_ptr_q];
  assign bus.FULL      = full;
  assign bus.WORD_CNT  = word_cnt_q;
  assign bus.HB_CNT    = hb_cnt_q;
endmodule

// File: doc/tpx3_out_stage.md
Name: tpx3_out_stage

Overview:
- Elastic buffer between the readout arbiter output and the BRAM output FIFO.
- Decouples arbiter grant timing from BRAM FIFO write timing with a small register FIFO.
- Counts forwarded data words.
- Inserts a heartbeat word when the stream has been idle for a programmed number of cycles, so software can tell "no hits" apart from "dead link".

Parameters:
- DEPTH, 4, buffer depth in 32-bit words; power of two, minimum 2.
- HB_IDENTIFIER, 4'b1010, value placed in heartbeat word bits [31:28].
- HB_PERIOD_WIDTH, 24, width of the HB_PERIOD input and of the idle counter.

Ports:
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST_N  in  1  asynchronous, active-low reset.
- IN_EMPTY  in  1  upstream FIFO empty; IN_DATA is valid whenever low (first-word-fall-through).
- IN_DATA  in  32  upstream data word.
- IN_READ  out  1  pops upstream; combinational.
- OUT_READ  in  1  downstream pop request.
- OUT_EMPTY  out  1  buffer empty.
- OUT_DATA  out  32  head-of-buffer word; valid when OUT_EMPTY is low.
- HB_EN  in  1  heartbeat insertion enable; static or quasi-static.
- HB_PERIOD  in  HB_PERIOD_WIDTH  idle cycles before a heartbeat; 0 disables insertion.
- WORD_CNT  out  32  data words accepted from upstream; wraps modulo 2^32.
- HB_CNT  out  28  heartbeat words inserted; wraps modulo 2^28.
- FULL  out  1  buffer holds DEPTH words.

Behaviour:
- Reset (BUS_RST_N low, asynchronous):
  - buffer count = 0, so OUT_EMPTY = 1 and FULL = 0.
  - OUT_DATA = 0, WORD_CNT = 0, HB_CNT = 0.
  - idle counter = 0, hb_pending = 0.
  - Release is synchronous to BUS_CLK; the first push is possible in the first cycle after release.
  - Reset mid-stream discards all buffered words with no partial output.
- Storage:
  - Circular register array with wr_ptr and rd_ptr, log2(DEPTH) bits each, wrapping at DEPTH.
  - Count register holds 0..DEPTH.
  - OUT_DATA = mem[rd_ptr], registered read-out with no bubble.
  - FULL = (count == DEPTH); OUT_EMPTY = (count == 0).
- Upstream handshake:
  - IN_READ = !IN_EMPTY && !FULL.
  - When IN_READ is high, IN_DATA is written to mem[wr_ptr] on that clock edge; wr_ptr and WORD_CNT increment.
  - No combinational path from OUT_READ to IN_READ. When the buffer is full, a push waits one cycle even if a pop occurs in the same cycle.
- Downstream:
  - OUT_READ with OUT_EMPTY low pops one word and increments rd_ptr.
  - OUT_READ while empty is ignored: no pointer change, no error.
- Simultaneous push and pop: count unchanged, both pointers advance, and data order is preserved.
- Latency: a word accepted in cycle N is visible on OUT_DATA (OUT_EMPTY low) in cycle N+1 if the buffer was empty.
- Heartbeat, idle counter:
  - When HB_EN = 1 and HB_PERIOD != 0, the idle counter increments every cycle in which no upstream word is accepted.
  - It clears to 0 in any cycle with a data push, and in any cycle where HB_EN = 0 or HB_PERIOD = 0.
- Heartbeat, triggering: when the idle counter reaches HB_PERIOD - 1 in a non-push cycle, the counter clears and hb_pending sets.
- Heartbeat, emission:
  - While hb_pending = 1 and the buffer is not full, the word {HB_IDENTIFIER, HB_CNT} is pushed using the pre-increment HB_CNT value.
  - In that push cycle, HB_CNT increments and hb_pending clears.
  - The emitted word has bit [27:0] = HB_CNT before increment (first heartbeat carries 0).
- Priority:
  - An upstream data push always wins a cycle over a heartbeat push.
  - Any data push clears hb_pending; data proves liveness, so the heartbeat is dropped rather than delayed.
  - At most one pending heartbeat exists; an idle period expiring while one is pending does not queue a second.
- Heartbeat while full: hb_pending waits; the idle counter keeps running but does not re-trigger.
- Arithmetic: all counters wrap silently with no saturation. An HB_PERIOD change takes effect on the next idle-counter compare.

Test Plan:
- Reset, then a 3-word upstream burst 0x11111111/0x22222222/0x33333333 with OUT_READ held 1 -> words appear in order, each one cycle after its IN_READ; WORD_CNT = 3; no heartbeat with HB_EN = 0.
- Upstream continuously non-empty, OUT_READ = 0 -> IN_READ deasserts after exactly DEPTH = 4 accepts and FULL = 1. Then OUT_READ pulsed one cycle -> exactly one more word accepted on the following cycle.
- HB_EN = 1, HB_PERIOD = 10, no upstream data -> the first heartbeat word 0xA0000000 is pushed on idle cycle 10 (idle counter 0..9), the second 0xA0000001 ten cycles later; HB_CNT = 2.
- HB_EN = 1, HB_PERIOD = 5, buffer held full with OUT_READ = 0 for 20 idle cycles, then one pop -> exactly one heartbeat word is pushed into the freed slot, never two.
- HB_PERIOD = 5, a data word arrives in the same cycle hb_pending is set (buffer full) -> pending is cleared, no heartbeat is emitted, and WORD_CNT increments.
- Assert BUS_RST_N low asynchronously mid-clock with 3 words buffered -> OUT_EMPTY = 1, WORD_CNT = 0, HB_CNT = 0 immediately. After release, a single new word is output alone.
